// File: rtl/watch_display_scan.sv
// Multiplexed 4-digit common-anode 7-segment scanner for the watch time digits,
// with anti-ghost blanking, hour leading-zero suppression, colon and set-mode blink.
module watch_display_scan #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 2,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hr1,
  input  logic [3:0] hr0,
  input  logic [3:0] min1,
  input  logic [3:0] min0,
  input  logic       set_mode,
  input  logic       set_field,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned BCNT_W = $clog2(BLINK_DIV);

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [1:0]        idx, idx_d;
  logic [BCNT_W-1:0] bcnt, bcnt_d;
  logic              ph, ph_d;
  logic              set_mode_q;
  logic [3:0]        an_d;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic [3:0]        digit;
  logic              in_field;
  logic              dark;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // Scan and blink counters, plus next-output computation from pre-edge state
  always_comb begin
    cnt_d    = cnt + CNT_W'(1);
    idx_d    = idx;
    bcnt_d   = bcnt + BCNT_W'(1);
    ph_d     = ph;
    an_d     = 4'b1111;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    digit    = min0;
    in_field = 1'b0;
    dark     = 1'b0;

    if (cnt == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx + 2'd1;
    end

    // Entering set mode restarts the blink so the edited field is shown first
    if (set_mode && !set_mode_q) begin
      bcnt_d = '0;
      ph_d   = 1'b0;
    end else if (bcnt == BCNT_W'(BLINK_DIV - 1)) begin
      bcnt_d = '0;
      ph_d   = ~ph;
    end

    case (idx)
      2'd0:    digit = min0;
      2'd1:    digit = min1;
      2'd2:    digit = hr0;
      default: digit = hr1;
    endcase

    in_field = set_field ? idx[1] : ~idx[1];
    dark     = (cnt < CNT_W'(BLANK_CYC))
             || (idx == 2'd3 && hr1 == 4'd0)
             || (set_mode && ph && in_field);

    if (!dark) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = seg_decode(digit);
      dp_d  = !(idx == 2'd2 && !ph);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      bcnt       <= '0;
      ph         <= 1'b0;
      set_mode_q <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
    end else begin
      cnt        <= cnt_d;
      idx        <= idx_d;
      bcnt       <= bcnt_d;
      ph         <= ph_d;
      set_mode_q <= set_mode;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
    end
  end

endmodule

// File: tb/tb_watch_display_scan.sv
// Bench for watch_display_scan: directed scenarios plus random digits/modes,
// checked against a time-based reference model of scan position and blink phase.
module tb_watch_display_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] hr1, hr0, min1, min0;
  logic       set_mode, set_field;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cycles since reset and cycles since last blink restart
  int t = 0;
  int tb = 0;
  bit prev_sm = 1'b0;
  logic [6:0] seg_tab [16];

  watch_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0),
    .set_mode(set_mode), .set_field(set_field), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic int m_cnt(); return t % SD; endfunction
  function automatic int m_idx(); return (t / SD) % 4; endfunction
  function automatic int m_ph();  return (tb / BD) % 2; endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // One clock edge: predict outputs from pre-edge model state, advance, compare
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] dig;
    int c, i, p;
    bit dark;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (!reset) begin
      c = m_cnt(); i = m_idx(); p = m_ph();
      dig = (i == 0) ? min0 : (i == 1) ? min1 : (i == 2) ? hr0 : hr1;
      dark = (c < BC) || (i == 3 && hr1 == 4'd0)
          || (set_mode && p == 1 && (set_field ? (i >= 2) : (i < 2)));
      if (!dark) begin
        e_an[i] = 1'b0;
        e_seg   = seg_tab[dig];
        e_dp    = !(i == 2 && p == 0);
      end
    end
    @(posedge clk);
    if (reset) begin
      t = 0; tb = 0; prev_sm = 1'b0;
    end else begin
      t++;
      if (set_mode && !prev_sm) tb = 0;
      else tb++;
      prev_sm = set_mode;
    end
    #1;
    chk("an", {3'b000, an}, {3'b000, e_an});
    chk("seg", seg, e_seg);
    chk("dp", {6'd0, dp}, {6'd0, e_dp});
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until the model's pre-edge position matches; expiry is a failure
  task automatic run_to(input int c, input int i, input int need_ph);
    int guard = 0;
    while (!(m_cnt() == c && m_idx() == i && (need_ph < 0 || m_ph() == need_ph))
           && guard < 500) begin
      step();
      guard++;
    end
    vectors++;
    assert (guard < 500) else begin
      miscompares++;
      $error("FAIL run_to: observed timeout expected cnt=%0d idx=%0d", c, i);
    end
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d);
    hr1 = a; hr0 = b; min1 = c; min0 = d;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) seg_tab[k] = 7'b0111111;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    reset = 1'b1; set_mode = 1'b0; set_field = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    steps(2);
    chk("reset_an", {3'b000, an}, 7'h0F);
    chk("reset_seg", seg, 7'h7F);

    // Scenario 1: release reset with 12:34
    reset = 1'b0;
    steps(2);
    chk("s1_blank_an", {3'b000, an}, 7'h0F);
    step();
    chk("s1_min0_an", {3'b000, an}, {3'b000, 4'b1110});
    chk("s1_min0_seg", seg, 7'b0011001);
    steps(5);
    steps(2);
    chk("s1_gap_an", {3'b000, an}, 7'h0F);
    step();
    chk("s1_min1_an", {3'b000, an}, {3'b000, 4'b1101});
    chk("s1_min1_seg", seg, 7'b0110000);

    // Scenario 2: 09:45 leading-zero suppression and colon
    set_digits(4'd0, 4'd9, 4'd4, 4'd5);
    steps(70);

    // Scenario 3: hours field blinking in set mode
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    set_field = 1'b1; set_mode = 1'b1;
    steps(100);

    // Scenario 4: out-of-range digit then mid-slot change
    set_mode = 1'b0;
    min0 = 4'hC;
    run_to(4, 0, -1);
    step();
    chk("s4_dash", seg, 7'b0111111);
    min0 = 4'd7;
    step();
    chk("s4_seven", seg, 7'b1111000);

    // Scenario 5: reset mid-slot
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run_to(5, 2, -1);
    reset = 1'b1;
    step();
    chk("s5_an", {3'b000, an}, 7'h0F);
    chk("s5_dp", {6'd0, dp}, 7'd1);
    reset = 1'b0;
    steps(3);
    chk("s5_restart_an", {3'b000, an}, {3'b000, 4'b1110});

    // Scenario 6: switch field during the dark phase
    set_field = 1'b0;
    run_to(0, 0, -1);
    set_mode = 1'b1;
    step();
    run_to(3, 2, 1);
    set_field = 1'b1;
    step();
    chk("s6_dark_an", {3'b000, an}, 7'h0F);
    steps(40);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0)
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 19) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 29) == 0) set_field = ~set_field;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
